pcs25g_tx_gearbox: RTL and testbench
====================================

Name: pcs25g_tx_gearbox

Overview:
- Transmit-side counterpart of the 25G PCS block-lock/descrambler receive path.
- Accepts 66-bit blocks (2-bit sync header plus 64-bit payload) from the PCS encoder.
- Scrambles each payload with the self-synchronous x^58+x^39+1 scrambler, then packs the 66-bit stream into continuous 64-bit words for the FEC/SerDes side.
- Inserts idle control blocks when the encoder has nothing to send, so the line never starves.

Parameters:
- SCR_INIT, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded on reset.
- IDLE_PAYLOAD, 64'h0000_0000_0000_001E, unscrambled payload of an inserted idle block (type 0x1E, all /I/).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  encoder offers a block.
- in_ready  output  1  gearbox accepts a block this cycle.
- in_sh  input  2  sync header; in_sh[0] transmitted first; 2'b10 = data, 2'b01 = control.
- in_data  input  64  unscrambled payload; bit 0 transmitted first.
- out_data  output  64  line word; bit 0 transmitted first.
- out_seq  output  6  gearbox phase, 0..32.
- idle_ins  output  1  pulse: an idle block was inserted this cycle.

Behaviour:
- State:
  - 128-bit buffer buf.
  - Fill count cnt, 0..64.
  - 58-bit scrambler state scr.
  - Phase counter seq.
- Reset values:
  - cnt=0, seq=0, scr=SCR_INIT, buf=0.
  - out_data=0, idle_ins=0.
  - in_ready=1 in the first cycle after reset.
- Transfer rule:
  - in_ready = (cnt<64), combinational from registered cnt only; no in_valid dependence.
  - When in_ready=1 a block is always consumed:
    - If in_valid=1: consume {in_data, in_sh}.
    - If in_valid=0: consume {IDLE_PAYLOAD, 2'b01} and pulse idle_ins=1 next cycle, aligned with out_data.
  - The encoder must hold the block stable while in_ready=0.
- Scrambler:
  - Applies only to the consumed payload; the sync header is never scrambled.
  - Scrambled bit k = d_k ^ o_(k-39) ^ o_(k-58), where o is scrambled history and pre-block history is taken from scr.
  - After each consumed block, scr is updated with the 58 most recent scrambled bits.
  - scr is unchanged in cycles where nothing is consumed.
- Packing, each cycle:
  - If consuming, the 66-bit word {scrambled, sh} is appended at bit position cnt of buf and cnt+=66.
  - The low 64 bits of the result are registered to out_data, buf shifts right by 64, and cnt-=64.
  - Net effect: cnt steps 0→2→4…→62→64→0.
  - Exactly 32 blocks are consumed per 33 cycles; in_ready=0 exactly when cnt==64.
- out_seq increments 0..32 and wraps to 0; it reads 32 in the cycle in_ready=0.
- Latency: a block consumed in cycle N has its sync header at out_data[cnt+1:cnt] in cycle N+1.
- Boundary conditions:
  - cnt never exceeds 128 bits buffered.
  - When cnt==64 the buffer is drained fully with no append.
  - Reset mid-stream discards buf contents and restarts at phase 0 with scr=SCR_INIT; no partial word is output.
  - in_valid toggling is legal every cycle; each gap produces exactly one idle block per gearbox slot.

Optional Feature:
- Macro: PCS25G_TX_ERRINJ_EN.
- When defined, adds two ports:
  - inj_req  input  1  one-shot request.
  - inj_mode  input  2  corruption type.
- inj_req is latched, and the corruption applies to the next consumed block, idle or data:
  - 2'b01: sync header forced to 2'b00.
  - 2'b10: sync header forced to 2'b11.
  - 2'b11: scrambled payload bit 0 inverted.
  - 2'b00: no effect.
- The pending request clears after being applied.
- A new inj_req while one is pending is ignored.
- Scrambler history always uses the uncorrupted scrambled bits.
- Reset clears any pending request.
- When the macro is undefined, the ports are absent and behaviour is as above.

Test Plan:
- Reset release, in_valid=1, in_sh=2'b10, in_data=0 → first out_data=64'h0FFF_FE00_0000_0002.
- Continuous in_valid=1 for 330 cycles → in_ready low in exactly 10 cycles (every 33rd, out_seq==32); 320 blocks consumed.
- in_valid=0 for 40 cycles → idle_ins high on every consumed slot; a descrambler model recovers sh=2'b01 and payload 64'h1E.
- Random blocks with random in_valid gaps → a reference receiver (66b realign plus descramble) reproduces the accepted sequence bit-exactly with idles interleaved.
- Assert rst mid-stream at cnt=30 → next cycle cnt=0, out_seq=0, out_data=0; the following block matches the post-reset vector of scenario 1.
- (PCS25G_TX_ERRINJ_EN) inj_req with inj_mode=2'b01 → exactly one received block has sync header 2'b00; subsequent payloads still descramble correctly.

Source files
------------

// File: rtl/pcs25g_tx_gearbox_if.sv
// Encoder-to-gearbox block handshake plus the 64-bit line-side word bus.
// The master side is the encoder; the slave side is the gearbox.
interface pcs25g_tx_gearbox_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sh;
    logic [63:0] in_data;
    logic [63:0] out_data;
    logic [5:0]  out_seq;
    logic        idle_ins;

    modport master (
        output in_valid, in_sh, in_data,
        input  in_ready, out_data, out_seq, idle_ins
    );

    modport slave (
        input  in_valid, in_sh, in_data,
        output in_ready, out_data, out_seq, idle_ins
    );
endinterface

// File: rtl/pcs25g_tx_gearbox.sv
// 25G PCS transmit gearbox: x^58+x^39+1 payload scrambler, idle insertion, 66b->64b packing.
// Optional error injection on the next consumed block when PCS25G_TX_ERRINJ_EN is defined.
module pcs25g_tx_gearbox #(
    parameter logic [57:0] SCR_INIT     = 58'h3FF_FFFF_FFFF_FFFF,
    parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E
) (
    input  logic clk,
    input  logic rst,
`ifdef PCS25G_TX_ERRINJ_EN
    input  logic       inj_req,
    input  logic [1:0] inj_mode,
`endif
    pcs25g_tx_gearbox_if.slave bus
);

    logic [6:0]   cnt;
    logic [5:0]   seq;
    logic [57:0]  scr;
    logic [127:0] buf_q;
    logic [63:0]  out_data_q;
    logic         idle_q;

    logic         consume;
    logic [1:0]   blk_sh;
    logic [63:0]  blk_pay;
    logic [38:0]  o_lo;
    logic [18:0]  o_mid;
    logic [5:0]   o_hi;
    logic [63:0]  scr_pay;
    logic [1:0]   line_sh;
    logic [63:0]  line_pay;
    logic [127:0] merged;

    // Two slots of buffering never hold more than 62+66 bits, so 128 suffices.
    assign consume      = (cnt < 7'd64);
    assign bus.in_ready = consume;
    assign bus.out_data = out_data_q;
    assign bus.out_seq  = seq;
    assign bus.idle_ins = idle_q;

    assign blk_sh  = bus.in_valid ? bus.in_sh   : 2'b01;
    assign blk_pay = bus.in_valid ? bus.in_data : IDLE_PAYLOAD;

    // scr[57] is the most recent scrambled bit, scr[0] the oldest (o at k-58).
    // Bits 39+ reuse freshly scrambled bits of this block, split to avoid a self-loop.
    assign o_lo    = blk_pay[38:0]  ^ scr[57:19] ^ scr[38:0];
    assign o_mid   = blk_pay[57:39] ^ o_lo[18:0] ^ scr[57:39];
    assign o_hi    = blk_pay[63:58] ^ o_lo[24:19] ^ o_lo[5:0];
    assign scr_pay = {o_hi, o_mid, o_lo};

`ifdef PCS25G_TX_ERRINJ_EN
    logic       inj_pend;
    logic [1:0] inj_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pend   <= 1'b0;
            inj_mode_q <= 2'b00;
        end else if (inj_pend && consume) begin
            inj_pend   <= 1'b0;
        end else if (!inj_pend && inj_req) begin
            inj_pend   <= 1'b1;
            inj_mode_q <= inj_mode;
        end
    end

    // Corruption touches only the line copy; scr always advances from scr_pay.
    always_comb begin
        line_sh  = blk_sh;
        line_pay = scr_pay;
        if (inj_pend) begin
            case (inj_mode_q)
                2'b01:   line_sh = 2'b00;
                2'b10:   line_sh = 2'b11;
                2'b11:   line_pay[0] = ~scr_pay[0];
                default: ;
            endcase
        end
    end
`else
    assign line_sh  = blk_sh;
    assign line_pay = scr_pay;
`endif

    assign merged = buf_q | (consume ? ({62'b0, line_pay, line_sh} << cnt) : 128'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 7'd0;
            seq        <= 6'd0;
            scr        <= SCR_INIT;
            buf_q      <= 128'b0;
            out_data_q <= 64'b0;
            idle_q     <= 1'b0;
        end else begin
            cnt        <= consume ? cnt + 7'd2 : 7'd0;
            seq        <= (seq == 6'd32) ? 6'd0 : seq + 6'd1;
            buf_q      <= {64'b0, merged[127:64]};
            out_data_q <= merged[63:0];
            idle_q     <= consume && !bus.in_valid;
            if (consume) begin
                scr <= scr_pay[63:6];
            end
        end
    end

endmodule

// File: tb/tb_pcs25g_tx_gearbox.sv
// Bench for pcs25g_tx_gearbox: serial bit-stream model of scrambler and line, plus a 66b receiver.
module tb_pcs25g_tx_gearbox;

    localparam logic [57:0] SCR_INIT     = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E;
    localparam logic [63:0] FIRST_WORD   = 64'h0FFF_FE00_0000_0002;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcs25g_tx_gearbox_if bus();

`ifdef PCS25G_TX_ERRINJ_EN
    logic       inj_req  = 1'b0;
    logic [1:0] inj_mode = 2'b00;
`endif

    pcs25g_tx_gearbox dut (
        .clk      (clk),
        .rst      (rst),
`ifdef PCS25G_TX_ERRINJ_EN
        .inj_req  (inj_req),
        .inj_mode (inj_mode),
`endif
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    int          phase;
    bit          line_q[$];
    bit          rx_q[$];
    logic [65:0] sent_q[$];
    logic [57:0] tx_hist;
    logic [57:0] rx_hist;
    int          ready_low;
    int          data_blocks;
    int          sh00_seen;
    bit          inj_now;
    bit          pend;
    logic [1:0]  pmode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        line_q.delete();
        rx_q.delete();
        sent_q.delete();
        tx_hist = SCR_INIT;
        rx_hist = SCR_INIT;
        pend    = 1'b0;
        pmode   = 2'b00;
    endtask

    // Receiver: realign 66-bit blocks from the line and descramble serially.
    task automatic receive(input logic [63:0] word);
        logic [1:0]  sh;
        logic [63:0] pay;
        logic [65:0] exp_blk;
        bit          o;
        for (int i = 0; i < 64; i++) rx_q.push_back(word[i]);
        while (rx_q.size() >= 66) begin
            sh[0] = rx_q.pop_front();
            sh[1] = rx_q.pop_front();
            for (int k = 0; k < 64; k++) begin
                o       = rx_q.pop_front();
                pay[k]  = o ^ rx_hist[38] ^ rx_hist[57];
                rx_hist = {rx_hist[56:0], o};
            end
            if (sh == 2'b00) sh00_seen++;
            if (sent_q.size() == 0) begin
                chk("rx_block_unexpected", {pay, sh}, 64'hx);
            end else begin
                exp_blk = sent_q.pop_front();
                chk("rx_sh", {62'b0, sh}, {62'b0, exp_blk[1:0]});
                chk("rx_payload", pay, exp_blk[65:2]);
            end
        end
    endtask

    // One clock: drive at negedge (held while not ready), model the slot, check after the edge.
    task automatic step(input bit v, input logic [1:0] sh, input logic [63:0] d);
        bit          slot;
        bit          exp_idle;
        logic [1:0]  bsh;
        logic [1:0]  lsh;
        logic [63:0] bpay;
        logic [63:0] spay;
        logic [63:0] ev;
        bit          o;
        @(negedge clk);
        slot = (phase != 32);
        if (slot) begin
            bus.in_valid = v;
            bus.in_sh    = sh;
            bus.in_data  = d;
        end
`ifdef PCS25G_TX_ERRINJ_EN
        inj_req = inj_now;
`endif
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, slot});
        chk("out_seq", {58'b0, bus.out_seq}, 64'(phase));
        if (!bus.in_ready) ready_low++;
        exp_idle = 1'b0;
        if (slot) begin
            bsh  = bus.in_valid ? bus.in_sh   : 2'b01;
            bpay = bus.in_valid ? bus.in_data : IDLE_PAYLOAD;
            if (bus.in_valid) data_blocks++;
            exp_idle = !bus.in_valid;
            for (int k = 0; k < 64; k++) begin
                o       = bpay[k] ^ tx_hist[38] ^ tx_hist[57];
                spay[k] = o;
                tx_hist = {tx_hist[56:0], o};
            end
            lsh = bsh;
            if (pend) begin
                if (pmode == 2'b01) lsh = 2'b00;
                if (pmode == 2'b10) lsh = 2'b11;
                if (pmode == 2'b11) spay[0] = ~spay[0];
                pend = 1'b0;
            end else if (inj_now) begin
                pend  = 1'b1;
                pmode = 2'b01;
            end
            line_q.push_back(lsh[0]);
            line_q.push_back(lsh[1]);
            for (int k = 0; k < 64; k++) line_q.push_back(spay[k]);
            sent_q.push_back({bpay, lsh});
        end else if (!pend && inj_now) begin
            pend  = 1'b1;
            pmode = 2'b01;
        end
        @(posedge clk);
        #1;
        ev = '0;
        for (int i = 0; i < 64; i++) ev[i] = (line_q.size() > 0) ? line_q.pop_front() : 1'b0;
        chk("out_data", bus.out_data, ev);
        chk("idle_ins", {63'b0, bus.idle_ins}, {63'b0, exp_idle});
        receive(bus.out_data);
        phase = (phase + 1) % 33;
        inj_now = 1'b0;
`ifdef PCS25G_TX_ERRINJ_EN
        inj_req = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_data", bus.out_data, 64'h0);
        chk("rst_out_seq", {58'b0, bus.out_seq}, 64'h0);
        chk("rst_idle_ins", {63'b0, bus.idle_ins}, 64'h0);
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'h1);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_step(input int gap_pct);
        bit v;
        v = ($urandom_range(99) >= gap_pct);
        step(v, $urandom_range(1) ? 2'b10 : 2'b01, {$urandom, $urandom});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sh    = 2'b10;
        bus.in_data  = 64'h0;
        inj_now      = 1'b0;
        ready_low    = 0;
        data_blocks  = 0;
        sh00_seen    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // First word after reset with an all-zero data block.
        step(1'b1, 2'b10, 64'h0);
        chk("first_word_literal", bus.out_data, FIRST_WORD);

        // Continuous valid for 330 cycles from a fresh reset.
        do_reset();
        ready_low   = 0;
        data_blocks = 0;
        for (int i = 0; i < 330; i++) step(1'b1, 2'b10, {$urandom, $urandom});
        chk("ready_low_count", 64'(ready_low), 64'd10);
        chk("blocks_consumed", 64'(data_blocks), 64'd320);

        // Encoder silent: every slot becomes an idle block.
        for (int i = 0; i < 40; i++) step(1'b0, 2'b10, 64'h0);

        // Random blocks with random gaps.
        for (int i = 0; i < 400; i++) rand_step(30);

        // Mid-stream reset at cnt=30 (phase 15), then the post-reset vector again.
        while (phase != 15) rand_step(20);
        do_reset();
        step(1'b1, 2'b10, 64'h0);
        chk("post_reset_literal", bus.out_data, FIRST_WORD);
        for (int i = 0; i < 200; i++) rand_step(50);

`ifdef PCS25G_TX_ERRINJ_EN
        sh00_seen = 0;
        do_reset();
        for (int i = 0; i < 10; i++) rand_step(30);
        inj_mode = 2'b01;
        inj_now  = 1'b1;
        step(1'b1, 2'b10, {$urandom, $urandom});
        for (int i = 0; i < 100; i++) rand_step(30);
        chk("errinj_sh00_count", 64'(sh00_seen), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
